sram_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single SRAM_1024x32 Wishbone slave port inside user_project_wrapper. Master 0 is the management SoC bus (wbs_*). Master 1 is a secondary user-side requester, such as a DMA or LA-driven test engine. The block does round-robin arbitration with bus lock for the duration of cyc. A watchdog terminates any transfer the slave fails to acknowledge.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arb_watchdog.sv | 34 +++
 rtl/sram_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_wb_arbiter.sv | 560 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM Wishbone arbiter.
// Imported by the watchdog and the arbiter top.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_arb_watchdog.sv
// Counts unacknowledged strobe cycles of the granted master and
// flags the cycle on which the transfer must be force-terminated.
module sram_arb_watchdog
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  assign expire = active & stb & ~ack & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || ack || expire) begin
      cnt <= '0;
    end else if (stb && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of one SRAM slave,
// with bus lock for the duration of cyc and a no-ack watchdog.
module sram_wb_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_t  state;
  logic        last_grant;
  logic        req0;
  logic        req1;
  logic        cyc;
  logic        stb_raw;
  logic        expire;
  logic        ack;
  logic [31:0] rdat;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= M1;
      grant_o    <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 && (!req1 || last_grant == M1)) begin
            state      <= GNT0;
            last_grant <= M0;
            grant_o    <= 2'b01;
          end else if (req1) begin
            state      <= GNT1;
            last_grant <= M1;
            grant_o    <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    cyc     = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    unique case (1'b1)
      grant_o[0]: begin
        cyc     = m0_cyc_i;
        stb_raw = m0_cyc_i & m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      grant_o[1]: begin
        cyc     = m1_cyc_i;
        stb_raw = m1_cyc_i & m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  sram_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .active(cyc),
    .stb   (stb_raw),
    .ack   (s_ack_i),
    .expire(expire)
  );

  // A dropped cyc gates off any late slave ack for the abandoned transfer
  assign ack  = stb_raw & (s_ack_i | expire);
  assign rdat = expire ? TIMEOUT_DATA : s_dat_i;

  assign s_cyc_o   = cyc;
  assign s_stb_o   = stb_raw & ~expire;
  assign timeout_o = expire;

  assign m0_ack_o = grant_o[0] & ack;
  assign m1_ack_o = grant_o[1] & ack;
  assign m0_dat_o = grant_o[0] ? rdat : 32'h0;
  assign m1_dat_o = grant_o[1] ? rdat : 32'h0;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Randomized self-checking bench for sram_wb_arbiter with an SRAM slave
// model and a transaction-level reference of memory and grant order.
module tb_sram_wb_arbiter;

  localparam int          TO   = 8;
  localparam logic [31:0] TOD  = 32'hDEAD_BEEF;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_cyc = 2'b00;
  logic [1:0]  m_stb = 2'b00;
  logic [1:0]  m_we  = 2'b00;
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wd;
  logic        s_ack;
  logic        slv_ack = 1'b0;
  logic        stray = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] s_rd = 32'h0;
  logic [1:0]  grant;
  logic        tmo;
  logic [31:0] mem [1024];
  logic [1:0]  wcnt = 2'd0;
  logic [31:0] ref_mem [int];
  int          model_last;
  int          vec = 0;
  int          bad = 0;

  wire [1:0] m_ack = {m1_ack, m0_ack};

  assign s_ack = slv_ack | stray;

  always #5 clk = ~clk;

  sram_wb_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (TOD)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m_cyc[0]),
    .m0_stb_i (m_stb[0]),
    .m0_we_i  (m_we[0]),
    .m0_sel_i (m_sel[0]),
    .m0_adr_i (m_adr[0]),
    .m0_dat_i (m_dat[0]),
    .m0_ack_o (m0_ack),
    .m0_dat_o (m0_rd),
    .m1_cyc_i (m_cyc[1]),
    .m1_stb_i (m_stb[1]),
    .m1_we_i  (m_we[1]),
    .m1_sel_i (m_sel[1]),
    .m1_adr_i (m_adr[1]),
    .m1_dat_i (m_dat[1]),
    .m1_ack_o (m1_ack),
    .m1_dat_o (m1_rd),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wd),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rd),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  // SRAM slave with random 1..3 cycle ack latency
  always @(posedge clk) begin
    if (rst) begin
      slv_ack <= 1'b0;
      wcnt    <= 2'd0;
    end else if (slv_ack) begin
      slv_ack <= 1'b0;
    end else if (s_cyc && s_stb && !mute) begin
      if (wcnt == 2'd0) begin
        slv_ack <= 1'b1;
        wcnt    <= 2'($urandom_range(0, 2));
        s_rd    <= mem[s_adr[11:2]];
        if (s_we)
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[11:2]][8*b +: 8] <= s_wd[8*b +: 8];
      end else begin
        wcnt <= wcnt - 2'd1;
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic do_reset();
    m_cyc = 2'b00;
    m_stb = 2'b00;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
  endtask

  // Runs one single-beat transfer per requesting master, dropping cyc at ack
  task automatic run_pair(input logic [1:0] mask, input logic [1:0] we,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] s0, input logic [3:0] s1,
                          output logic [1:0] first, output int gap,
                          output logic [31:0] rd0, output logic [31:0] rd1,
                          output logic [1:0] done, output bit xack);
    logic [1:0] pend;
    first = 2'b00;
    gap   = 0;
    rd0   = 32'h0;
    rd1   = 32'h0;
    done  = 2'b00;
    xack  = 1'b0;
    m_adr[0] = a0;
    m_adr[1] = a1;
    m_dat[0] = d0;
    m_dat[1] = d1;
    m_sel[0] = s0;
    m_sel[1] = s1;
    m_we  = we;
    m_cyc = mask;
    m_stb = mask;
    pend  = mask;
    for (int c = 0; c < 80 && pend != 2'b00; c++) begin
      @(negedge clk);
      if (first == 2'b00 && grant != 2'b00) first = grant;
      if (done != 2'b00 && grant == 2'b00) gap++;
      if ((m_ack & ~pend) != 2'b00) xack = 1'b1;
      if (pend[0] && m_ack[0]) begin
        rd0 = m0_rd;
        pend[0] = 1'b0;
        done[0] = 1'b1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
      end
      if (pend[1] && m_ack[1]) begin
        rd1 = m1_rd;
        pend[1] = 1'b0;
        done[1] = 1'b1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
      end
    end
    m_cyc = 2'b00;
    m_stb = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    m_sel[0] = 4'hF;
    m_sel[1] = 4'hF;
    m_adr[0] = BASE;
    m_adr[1] = BASE;
    m_dat[0] = 32'h0;
    m_dat[1] = 32'h0;
    rst   = 1'b1;
    m_cyc = 2'b01;
    m_stb = 2'b01;
    repeat (2) @(negedge clk);
    vec++;
    if ({grant, s_cyc, s_stb, s_we, m_ack, tmo, s_sel} !== 11'h0) begin
      $display("FAIL reset_ctl got %h want 0",
               {grant, s_cyc, s_stb, s_we, m_ack, tmo, s_sel});
      bad++;
    end
    vec++;
    if ({s_adr, s_wd, m0_rd, m1_rd} !== 128'h0) begin
      $display("FAIL reset_data got %h want 0", {s_adr, s_wd, m0_rd, m1_rd});
      bad++;
    end
    m_cyc = 2'b00;
    m_stb = 2'b00;
    rst = 1'b0;
    model_last = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [1:0]  first, done;
    logic [31:0] r0, r1;
    int          gap;
    bit          xack, ok;
    xack = 1'b0;
    ok   = 1'b0;
    m_adr[0] = 32'h3000_0010;
    m_dat[0] = 32'h1234_5678;
    m_sel[0] = 4'hF;
    m_we[0]  = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    #1;
    vec++;
    if (s_cyc !== 1'b0) begin
      $display("FAIL single_lat0 got %b want 0", s_cyc);
      bad++;
    end
    @(negedge clk);
    vec++;
    if ({s_cyc, grant} !== 3'b101) begin
      $display("FAIL single_gnt got %b want 101", {s_cyc, grant});
      bad++;
    end
    for (int c = 0; c < 20; c++) begin
      if (m1_ack) xack = 1'b1;
      if (m0_ack) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vec++;
    if (!ok || xack) begin
      $display("FAIL single_wack got ok=%b x=%b want ok=1 x=0", ok, xack);
      bad++;
    end
    vec++;
    if ({s_adr, s_wd, s_we} !== {32'h3000_0010, 32'h1234_5678, 1'b1}) begin
      $display("FAIL single_path got %h want %h", {s_adr, s_wd, s_we},
               {32'h3000_0010, 32'h1234_5678, 1'b1});
      bad++;
    end
    ref_mem[4] = 32'h1234_5678;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    vec++;
    if ({s_cyc, s_stb, grant} !== 4'b0001) begin
      $display("FAIL single_rel got %b want 0001", {s_cyc, s_stb, grant});
      bad++;
    end
    @(negedge clk);
    vec++;
    if (grant !== 2'b00) begin
      $display("FAIL single_idle got %b want 00", grant);
      bad++;
    end
    run_pair(2'b01, 2'b00, 32'h3000_0010, BASE, 32'h0, 32'h0, 4'hF, 4'hF,
             first, gap, r0, r1, done, xack);
    model_last = 0;
    vec++;
    if ({first, done, xack} !== 5'b01010 || r0 !== ref_mem[4]) begin
      $display("FAIL single_read got g=%b d=%b x=%b rd=%h want 01 01 0 %h",
               first, done, xack, r0, ref_mem[4]);
      bad++;
    end
  endtask

  task automatic test_tie();
    logic [1:0]  first, done;
    logic [31:0] r0, r1;
    int          gap;
    bit          xack;
    do_reset();
    run_pair(2'b11, 2'b11, BASE + 32'h20, BASE + 32'h24,
             32'hA5A5_0001, 32'h5A5A_0002, 4'hF, 4'hF,
             first, gap, r0, r1, done, xack);
    ref_mem[8] = 32'hA5A5_0001;
    ref_mem[9] = 32'h5A5A_0002;
    model_last = 1;
    vec++;
    if (first !== 2'b01) begin
      $display("FAIL tie_first got %b want 01", first);
      bad++;
    end
    vec++;
    if (gap !== 1 || done !== 2'b11 || xack) begin
      $display("FAIL tie_gap got gap=%0d d=%b x=%b want 1 11 0",
               gap, done, xack);
      bad++;
    end
  endtask

  task automatic test_lock();
    logic [31:0] got [4];
    logic [31:0] wd;
    int          i;
    bit          viol, m0done;
    viol   = 1'b0;
    m0done = 1'b0;
    i      = 0;
    m_adr[1] = BASE + 32'h20;
    m_sel[1] = 4'hF;
    m_we[1]  = 1'b0;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    @(negedge clk);
    vec++;
    if (grant !== 2'b10) begin
      $display("FAIL lock_gnt1 got %b want 10", grant);
      bad++;
    end
    wd = $urandom;
    m_adr[0] = BASE + 32'h30;
    m_dat[0] = wd;
    m_sel[0] = 4'hF;
    m_we[0]  = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int c = 0; c < 120 && !m0done; c++) begin
      @(negedge clk);
      if (i < 4 && (grant[0] || m0_ack)) viol = 1'b1;
      if (i < 4 && m1_ack) begin
        got[i] = m1_rd;
        i++;
        if (i == 4) begin
          m_cyc[1] = 1'b0;
          m_stb[1] = 1'b0;
        end else begin
          m_adr[1] = BASE + 32'h20 + 32'((i % 2) * 4);
        end
      end else if (i == 4 && m0_ack) begin
        m0done = 1'b1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
      end
    end
    @(negedge clk);
    ref_mem[12] = wd;
    model_last = 0;
    vec++;
    if (viol || i != 4) begin
      $display("FAIL lock_hold got viol=%b n=%0d want 0 4", viol, i);
      bad++;
    end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (got[k] !== ref_mem[8 + (k % 2)]) begin
        $display("FAIL lock_rd%0d got %h want %h", k, got[k],
                 ref_mem[8 + (k % 2)]);
        bad++;
      end
    end
    vec++;
    if (!m0done) begin
      $display("FAIL lock_m0 got 0 want 1");
      bad++;
    end
  endtask

  task automatic test_timeout();
    int          n, pulses, at;
    logic [31:0] dat;
    logic        stbv, tmv;
    bit          hit;
    n = 0;
    pulses = 0;
    at = 0;
    hit = 1'b0;
    dat = 32'h0;
    stbv = 1'b1;
    tmv = 1'b0;
    mute = 1'b1;
    m_adr[0] = BASE + 32'h40;
    m_we[0]  = 1'b0;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (grant == 2'b01) n++;
      if (tmo) pulses++;
      if (m0_ack) begin
        hit = 1'b1;
        at = n;
        dat = m0_rd;
        stbv = s_stb;
        tmv = tmo;
      end
    end
    m_stb[0] = 1'b0;
    @(negedge clk);
    if (tmo) pulses++;
    vec++;
    if (!hit || at != TO) begin
      $display("FAIL to_cycle got hit=%b at=%0d want 1 %0d", hit, at, TO);
      bad++;
    end
    vec++;
    if (dat !== TOD || stbv !== 1'b0 || tmv !== 1'b1) begin
      $display("FAIL to_beat got d=%h stb=%b t=%b want %h 0 1",
               dat, stbv, tmv, TOD);
      bad++;
    end
    vec++;
    if (pulses != 1 || grant !== 2'b01 || m0_ack !== 1'b0) begin
      $display("FAIL to_after got p=%0d g=%b a=%b want 1 01 0",
               pulses, grant, m0_ack);
      bad++;
    end
    m_cyc[0] = 1'b0;
    mute = 1'b0;
    @(negedge clk);
    model_last = 0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] wd;
    bit          ok, sawg;
    ok   = 1'b0;
    sawg = 1'b0;
    wd   = $urandom;
    m_adr[1] = BASE + 32'h50;
    m_dat[1] = wd;
    m_sel[1] = 4'hF;
    m_we[1]  = 1'b1;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    @(negedge clk);
    vec++;
    if (grant !== 2'b10 || m1_ack !== 1'b0) begin
      $display("FAIL rstm_gnt got g=%b a=%b want 10 0", grant, m1_ack);
      bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({grant, s_cyc, m1_ack} !== 4'b0000) begin
      $display("FAIL rstm_clr got %b want 0000", {grant, s_cyc, m1_ack});
      bad++;
    end
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (grant == 2'b10) sawg = 1'b1;
      if (m1_ack) begin
        ok = 1'b1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
      end
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    @(negedge clk);
    ref_mem[20] = wd;
    model_last = 1;
    vec++;
    if (!ok || !sawg) begin
      $display("FAIL rstm_rearb got ack=%b g=%b want 1 1", ok, sawg);
      bad++;
    end
  endtask

  task automatic test_stray();
    stray = 1'b1;
    #1;
    vec++;
    if ({m_ack, tmo} !== 3'b000) begin
      $display("FAIL stray_ack got %b want 000", {m_ack, tmo});
      bad++;
    end
    @(negedge clk);
    stray = 1'b0;
    vec++;
    if ({grant, s_cyc} !== 3'b000) begin
      $display("FAIL stray_idle got %b want 000", {grant, s_cyc});
      bad++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  mask, we, first, done;
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] e [2];
    logic [31:0] r [2];
    logic [3:0]  s [2];
    int          idx [2];
    int          ord [2];
    int          gap, n, m;
    bit          xack;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        idx[k] = 32 + int'($urandom_range(0, 7));
        we[k]  = 1'($urandom);
        if (!we[k] && !ref_mem.exists(idx[k])) we[k] = 1'b1;
        s[k] = ref_mem.exists(idx[k]) ? 4'($urandom_range(1, 15)) : 4'hF;
        d[k] = $urandom;
        a[k] = BASE + 32'(idx[k] * 4);
        e[k] = 32'h0;
      end
      if (mask == 2'b11) begin
        ord[0] = (model_last == 1) ? 0 : 1;
        ord[1] = 1 - ord[0];
        n = 2;
      end else begin
        ord[0] = (mask == 2'b01) ? 0 : 1;
        ord[1] = ord[0];
        n = 1;
      end
      for (int k = 0; k < n; k++) begin
        m = ord[k];
        if (we[m])
          ref_mem[idx[m]] = merge(ref_mem.exists(idx[m]) ?
                                  ref_mem[idx[m]] : 32'h0, d[m], s[m]);
        else
          e[m] = ref_mem[idx[m]];
      end
      model_last = ord[n-1];
      run_pair(mask, we, a[0], a[1], d[0], d[1], s[0], s[1],
               first, gap, r[0], r[1], done, xack);
      vec++;
      if (first !== 2'(1 << ord[0]) || done !== mask || xack) begin
        $display("FAIL rnd_arb it%0d got g=%b d=%b x=%b want %b %b 0",
                 it, first, done, xack, 2'(1 << ord[0]), mask);
        bad++;
      end
      if (mask == 2'b11) begin
        vec++;
        if (gap != 1) begin
          $display("FAIL rnd_gap it%0d got %0d want 1", it, gap);
          bad++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (mask[k] && !we[k]) begin
          vec++;
          if (r[k] !== e[k]) begin
            $display("FAIL rnd_rd it%0d m%0d got %h want %h",
                     it, k, r[k], e[k]);
            bad++;
          end
        end
      end
    end
  endtask

  initial begin
    model_last = 1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_timeout();
    test_rst_mid();
    test_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
